// File: rtl/la_pkg.sv
// Shared types and helpers for the logic-analyzer capture path.
package la_pkg;

    localparam int unsigned SMPL_DEPTH = 384;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE   = 3'd1,
        ARMED = 3'd2,
        POST  = 3'd3,
        DONE  = 3'd4
    } capture_state_t;

    // Circular successor of addr in a RAM of the given depth (need not be a power of two).
    function automatic int unsigned next_addr(input int unsigned addr, input int unsigned depth);
        return (addr >= depth - 1) ? 0 : addr + 1;
    endfunction

endpackage

// File: rtl/capture_addr_ctr.sv
// Wrapping sample-RAM write pointer: clr returns to 0, inc advances with DEPTH-1 -> 0 wrap.
module capture_addr_ctr
    import la_pkg::*;
#(
    parameter int unsigned DEPTH = SMPL_DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [AW-1:0] addr
);

    logic [AW-1:0] addr_q;
    logic [AW-1:0] addr_d;

    always_comb begin
        addr_d = addr_q;
        if (clr) begin
            addr_d = '0;
        end else if (inc) begin
            addr_d = AW'(next_addr(32'(addr_q), DEPTH));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr = addr_q;

endmodule

// File: rtl/capture_ctrl.sv
// Capture sequencer: pre-trigger fill, circular armed writing, post-trigger
// count-down and sticky done, driving the sample RAM write port.
module capture_ctrl
    import la_pkg::*;
#(
    parameter int unsigned DEPTH = SMPL_DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wrt_smpl,
    input  logic          trig,
    input  logic          capture_start,
    input  logic          abort,
    input  logic          done_clr,
    input  logic [AW-1:0] trig_pos,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic          set_armed,
    output logic          busy,
    output logic          capture_done,
    output logic [AW-1:0] trig_addr
);

    localparam int unsigned CW = AW + 1;

    capture_state_t state_q, state_d;
    logic [AW-1:0]  tp_q, tp_d;
    logic [AW-1:0]  pre_cnt_q, pre_cnt_d;
    logic [AW-1:0]  pre_inc;
    logic [AW-1:0]  trig_addr_q, trig_addr_d;
    logic [CW-1:0]  post_cnt_q, post_cnt_d;
    logic [CW-1:0]  post_load;
    logic           set_armed_q, set_armed_d;
    logic           busy_q, busy_d;
    logic           capture_done_q, capture_done_d;
    logic           active;
    logic           ptr_clr;

    // Writes are zero-latency from the strobe; abort suppresses the write of its own clk.
    assign active = (state_q == PRE) || (state_q == ARMED) || (state_q == POST);
    assign we     = wrt_smpl && active && !abort;

    capture_addr_ctr #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_addr_ctr (
        .clk  (clk),
        .rst  (rst),
        .clr  (ptr_clr),
        .inc  (we),
        .addr (waddr)
    );

    // A write coincident with the trigger is already the first post-trigger sample.
    assign post_load = CW'(DEPTH) - CW'(tp_q) - CW'(we);
    assign pre_inc   = pre_cnt_q + AW'(1);

    always_comb begin
        state_d     = state_q;
        tp_d        = tp_q;
        pre_cnt_d   = pre_cnt_q;
        trig_addr_d = trig_addr_q;
        post_cnt_d  = post_cnt_q;
        ptr_clr     = 1'b0;

        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (capture_start) begin
                        ptr_clr   = 1'b1;
                        pre_cnt_d = '0;
                        tp_d      = trig_pos;
                        state_d   = (trig_pos == '0) ? ARMED : PRE;
                    end else if ((state_q == DONE) && done_clr) begin
                        state_d = IDLE;
                    end
                end
                PRE: begin
                    if (we) begin
                        pre_cnt_d = pre_inc;
                        if (pre_inc == tp_q) begin
                            state_d = ARMED;
                        end
                    end
                end
                ARMED: begin
                    if (trig) begin
                        trig_addr_d = waddr;
                        post_cnt_d  = post_load;
                        state_d     = (post_load == '0) ? DONE : POST;
                    end
                end
                POST: begin
                    if (we) begin
                        post_cnt_d = post_cnt_q - CW'(1);
                        if (post_cnt_q == CW'(1)) begin
                            state_d = DONE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Arm level rises the clk after ARMED entry and drops together with the exit.
        set_armed_d    = (state_q == ARMED) && (state_d == ARMED);
        busy_d         = (state_d == PRE) || (state_d == ARMED) || (state_d == POST);
        capture_done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            tp_q           <= '0;
            pre_cnt_q      <= '0;
            trig_addr_q    <= '0;
            post_cnt_q     <= '0;
            set_armed_q    <= 1'b0;
            busy_q         <= 1'b0;
            capture_done_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            tp_q           <= tp_d;
            pre_cnt_q      <= pre_cnt_d;
            trig_addr_q    <= trig_addr_d;
            post_cnt_q     <= post_cnt_d;
            set_armed_q    <= set_armed_d;
            busy_q         <= busy_d;
            capture_done_q <= capture_done_d;
        end
    end

    assign set_armed    = set_armed_q;
    assign busy         = busy_q;
    assign capture_done = capture_done_q;
    assign trig_addr    = trig_addr_q;

endmodule
